sha256_core_arbiter: RTL and testbench

//  Shares one simplified_sha256 compression core among NUM_REQ requesters (e.g. nonce workers of the miner).

---
 rtl/sha256_core_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sha256_core_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_core_arbiter.sv
// Round-robin front end sharing one SHA-256 compression core among requesters.
// Latches the granted job, drives the core, watches for a hang, returns tagged digests.
module sha256_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 96,
    parameter int RST_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*512-1:0] req_msg,
    input  logic [NUM_REQ*256-1:0] req_iv,
    output logic                   core_start,
    output logic [511:0]           core_message,
    output logic [255:0]           core_in,
    output logic                   core_reset_n,
    input  logic                   core_done,
    input  logic [255:0]           core_hash,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [255:0]           rsp_hash,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RECOVER,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic [511:0]    msg_q, msg_d;
    logic [255:0]    iv_q, iv_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic [255:0]    rsp_hash_q, rsp_hash_d;
    logic            rsp_err_q, rsp_err_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] cand;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_q) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && win_found) begin
            req_ready = NUM_REQ'(1) << win_id;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cur_id_d   = cur_id_q;
        msg_d      = msg_q;
        iv_d       = iv_q;
        wdog_d     = wdog_q;
        rcnt_d     = rcnt_q;
        rsp_hash_d = rsp_hash_q;
        rsp_err_d  = rsp_err_q;
        rsp_id_d   = rsp_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    msg_d    = req_msg[int'(win_id)*512 +: 512];
                    iv_d     = req_iv[int'(win_id)*256 +: 256];
                    rr_d     = win_id;
                    cur_id_d = win_id;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wdog_q != WD_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
                // A done arriving on the last allowed cycle still counts.
                if (core_done) begin
                    rsp_hash_d = core_hash;
                    rsp_err_d  = 1'b0;
                    rsp_id_d   = cur_id_q;
                    state_d    = S_RESP;
                end else if (wdog_q == WD_LAST) begin
                    rsp_hash_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_id_d   = cur_id_q;
                    rcnt_d     = '0;
                    state_d    = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (rcnt_q == RC_LAST) begin
                    state_d = S_RESP;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= ID_W'(NUM_REQ - 1);
            cur_id_q   <= '0;
            msg_q      <= '0;
            iv_q       <= '0;
            wdog_q     <= '0;
            rcnt_q     <= '0;
            rsp_hash_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cur_id_q   <= cur_id_d;
            msg_q      <= msg_d;
            iv_q       <= iv_d;
            wdog_q     <= wdog_d;
            rcnt_q     <= rcnt_d;
            rsp_hash_q <= rsp_hash_d;
            rsp_err_q  <= rsp_err_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign core_start   = (state_q == S_ISSUE);
    assign core_reset_n = (state_q != S_RECOVER);
    assign core_message = msg_q;
    assign core_in      = iv_q;
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_id       = rsp_id_q;
    assign rsp_hash     = rsp_hash_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter: behavioural SHA-256 core with adjustable latency,
// directed scenarios plus randomized jobs checked against a reference compression.
module tb_sha256_core_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 96;
    localparam int RST_CYC = 2;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H_INIT =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] ABC_DIGEST =
        256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*512-1:0] req_msg;
    logic [N*256-1:0] req_iv;
    logic             core_start;
    logic [511:0]     core_message;
    logic [255:0]     core_in;
    logic             core_reset_n;
    logic             core_done;
    logic [255:0]     core_hash;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [255:0]     rsp_hash;
    logic             rsp_err;
    logic             busy;

    logic [511:0] msg_a [N];
    logic [255:0] iv_a  [N];
    int           lat_cfg;
    bit           stub;
    int           n_cmp = 0;
    int           n_err = 0;

    sha256_core_arbiter #(
        .NUM_REQ(N), .ID_W(2), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_msg(req_msg), .req_iv(req_iv),
        .core_start(core_start), .core_message(core_message),
        .core_in(core_in), .core_reset_n(core_reset_n),
        .core_done(core_done), .core_hash(core_hash),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_hash(rsp_hash),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_msg = '0;
        req_iv  = '0;
        for (int r = 0; r < N; r++) begin
            req_msg[r*512 +: 512] = msg_a[r];
            req_iv[r*256 +: 256]  = iv_a[r];
        end
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [511:0] m,
                                             input logic [255:0] h);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = m[i*32 +: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = w[i-16] + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        end
        a = h[0 +: 32];   b = h[32 +: 32];  c = h[64 +: 32];  d = h[96 +: 32];
        e = h[128 +: 32]; f = h[160 +: 32]; g = h[192 +: 32]; hh = h[224 +: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
               + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
               + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c;  c = b; b = a; a = t1 + t2;
        end
        res[0 +: 32]   = h[0 +: 32] + a;
        res[32 +: 32]  = h[32 +: 32] + b;
        res[64 +: 32]  = h[64 +: 32] + c;
        res[96 +: 32]  = h[96 +: 32] + d;
        res[128 +: 32] = h[128 +: 32] + e;
        res[160 +: 32] = h[160 +: 32] + f;
        res[192 +: 32] = h[192 +: 32] + g;
        res[224 +: 32] = h[224 +: 32] + hh;
        return res;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural core: done lat_cfg cycles after start, never when stubbed.
    int cnt;
    bit run;
    always @(posedge clk) begin
        if (reset || !core_reset_n) begin
            run       <= 1'b0;
            cnt       <= 0;
            core_done <= 1'b0;
            core_hash <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                run <= 1'b1;
                cnt <= lat_cfg;
            end else if (run) begin
                if (cnt <= 1) begin
                    run <= 1'b0;
                    if (!stub) begin
                        core_done <= 1'b1;
                        core_hash <= sha_blk(core_message, core_in);
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 50; i++) begin
            #1;
            if (|req_ready) break;
            @(negedge clk);
        end
    endtask

    task automatic job(input int r, input int lat, input bit stub_m);
        logic [255:0] eh;
        int k;
        int lowc;
        lat_cfg   = lat;
        stub      = stub_m;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_valid[r] = 1'b1;
        wait_grant();
        chk("job_grant", 256'(req_ready), 256'(N'(1) << r));
        eh = stub_m ? '0 : sha_blk(msg_a[r], iv_a[r]);
        k = 0;
        lowc = 0;
        while (!rsp_valid && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = '0;
            if (!core_reset_n) lowc++;
        end
        chk("job_rsp_valid", 256'(rsp_valid), 256'(1));
        chk("job_latency", 256'(k),
            256'(stub_m ? TIMEOUT + RST_CYC + 2 : lat + 3));
        chk("job_core_rst_low", 256'(lowc), 256'(stub_m ? RST_CYC : 0));
        chk("job_id", 256'(rsp_id), 256'(r));
        chk("job_hash", rsp_hash, eh);
        chk("job_err", 256'(rsp_err), 256'(stub_m));
        @(negedge clk);
        chk("job_rsp_drop", 256'(rsp_valid), 256'(0));
        stub = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int exp_id;
        logic [255:0] eh;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        stub      = 1'b0;
        lat_cfg   = 10;
        for (int r = 0; r < N; r++) begin
            msg_a[r] = rnd512();
            iv_a[r]  = rnd256();
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_core_start", 256'(core_start), 256'(0));
        chk("rst_core_reset_n", 256'(core_reset_n), 256'(1));
        chk("rst_rsp_id", 256'(rsp_id), 256'(0));
        chk("rst_rsp_hash", rsp_hash, '0);
        chk("rst_rsp_err", 256'(rsp_err), 256'(0));
        chk("rst_core_message", core_message[255:0], '0);
        chk("rst_core_in", core_in, '0);
        reset = 1'b0;

        // "abc" single block on requester 2, response held for 20 cycles
        msg_a[2] = '0;
        msg_a[2][31:0] = 32'h61626380;
        msg_a[2][511:480] = 32'h00000018;
        iv_a[2] = H_INIT;
        req_valid = 4'b0100;
        #1;
        chk("abc_ready", 256'(req_ready), 256'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        chk("abc_start", 256'(core_start), 256'(1));
        chk("abc_ready_drop", 256'(req_ready), 256'(0));
        k = 1;
        while (!rsp_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("abc_latency", 256'(k), 256'(13));
        chk("abc_id", 256'(rsp_id), 256'(2));
        chk("abc_hash", rsp_hash, ABC_DIGEST);
        chk("abc_err", 256'(rsp_err), 256'(0));
        req_valid = 4'b1011;
        repeat (20) begin
            @(negedge clk);
            chk("hold_valid", 256'(rsp_valid), 256'(1));
            chk("hold_id", 256'(rsp_id), 256'(2));
            chk("hold_hash", rsp_hash, ABC_DIGEST);
            chk("hold_ready", 256'(req_ready), 256'(0));
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", 256'(rsp_valid), 256'(0));
        chk("hold_idle", 256'(busy), 256'(0));

        // reset while the core is working
        lat_cfg = 60;
        req_valid = 4'b1000;
        #1;
        chk("rr_after_2", 256'(req_ready), 256'(4'b1000));
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        chk("midjob_busy", 256'(busy), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("midrst_msg", core_message[255:0], '0);
        reset = 1'b0;

        // all requesters valid: rotating grants with random data and latency
        req_valid = 4'b1111;
        exp_id = N - 1;
        for (int j = 0; j < 8; j++) begin
            exp_id = (exp_id + 1) % N;
            lat_cfg = $urandom_range(1, 70);
            wait_grant();
            chk("rr_grant", 256'(req_ready), 256'(N'(1) << exp_id));
            eh = sha_blk(msg_a[exp_id], iv_a[exp_id]);
            @(negedge clk);
            msg_a[exp_id] = rnd512();
            iv_a[exp_id]  = rnd256();
            k = 0;
            while (!rsp_valid && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("rr_id", 256'(rsp_id), 256'(exp_id));
            chk("rr_hash", rsp_hash, eh);
            chk("rr_err", 256'(rsp_err), 256'(0));
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);

        // hung core, then a normal job, then done exactly at the limit
        job(1, 10, 1'b1);
        job(1, 20, 1'b0);
        job(0, TIMEOUT - 1, 1'b0);
        job(3, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
